// File: rtl/conv2_scheduler.sv
// Stage-2 convolution sequencer: streams image/pattern beats into
// Conv2_Full per output position and writes each convSum to the output buffer.
module conv2_scheduler #(
  parameter int DATA_W     = 8,
  parameter int SUM_W      = 22,
  parameter int PACKET_LEN = 36,
  parameter int N_OUT      = 16,
  parameter int RESULT_LAT = 2,
  parameter int IMG_AW     = 10,
  parameter int PAT_AW     = 6,
  parameter int OUT_AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [IMG_AW-1:0] img_addr,
  output logic [PAT_AW-1:0] pat_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] img_data,
  input  logic [DATA_W-1:0] pat_data,
  output logic              conv_clr,
  output logic              conv_enable,
  output logic [DATA_W-1:0] conv_image,
  output logic [DATA_W-1:0] conv_pattern,
  input  logic              conv_packetRead,
  input  logic [SUM_W-1:0]  conv_sum,
  output logic              wr_en,
  output logic [OUT_AW-1:0] wr_addr,
  output logic [SUM_W-1:0]  wr_data
);

  localparam int KMAX =
    (PACKET_LEN > RESULT_LAT) ? PACKET_LEN : RESULT_LAT;
  localparam int KW = $clog2(KMAX + 1);

  localparam logic [KW-1:0] K_LEN  = KW'(PACKET_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(PACKET_LEN - 1);
  localparam logic [KW-1:0] K_LAT  = KW'(RESULT_LAT);
  localparam logic [KW-1:0] K_ONE  = KW'(1);

  localparam logic [OUT_AW-1:0] P_LAST = OUT_AW'(N_OUT - 1);
  localparam logic [OUT_AW-1:0] P_ONE  = OUT_AW'(1);

  localparam logic [IMG_AW-1:0] B_STEP = IMG_AW'(PACKET_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  // k counts beats in FEED and latency cycles in DRAIN
  logic [KW-1:0]     k_q, k_d;
  logic [OUT_AW-1:0] p_q, p_d;
  logic [IMG_AW-1:0] base_q, base_d;
  logic              en_q, en_d;

  logic rd;
  logic clr;
  logic wen;
  logic dn;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      p_q     <= '0;
      base_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      base_q  <= base_d;
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    base_d  = base_q;
    rd      = 1'b0;
    clr     = 1'b0;
    wen     = 1'b0;
    dn      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clr     = 1'b1;
        k_d     = '0;
        state_d = S_FEED;
      end
      S_FEED: begin
        if (conv_packetRead && (k_q < K_LEN)) begin
          rd  = 1'b1;
          k_d = k_q + K_ONE;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // first DRAIN cycle carries the final beat
        if (k_q == K_LAT) begin
          k_d     = '0;
          state_d = S_WRITE;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_WRITE: begin
        wen = 1'b1;
        if (p_q == P_LAST) begin
          state_d = S_DONE;
        end else begin
          p_d     = p_q + P_ONE;
          base_d  = base_q + B_STEP;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        dn      = 1'b1;
        p_d     = '0;
        base_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign en_d = rd;

  assign busy = (state_q != S_IDLE)
             && (state_q != S_DONE);

  assign done     = dn;
  assign conv_clr = clr;
  assign mem_rd   = rd;

  assign img_addr = rd ? (base_q + IMG_AW'(k_q)) : '0;
  assign pat_addr = rd ? PAT_AW'(k_q) : '0;

  assign conv_enable  = en_q;
  assign conv_image   = en_q ? img_data : '0;
  assign conv_pattern = en_q ? pat_data : '0;

  assign wr_en   = wen;
  assign wr_addr = wen ? p_q : '0;
  assign wr_data = wen ? conv_sum : '0;

endmodule
